tlp_completer: RTL

- Single-DW PCIe target endpoint that sits on the TLP-side Avalon-ST pair of the PCIe TLP adapter.
- Consumes memory request TLPs from the host (initiator) on the rx stream and returns completions on the tx stream.
- Backs a small 32-bit register file exposed through a BAR; it is the responder end of the host's MMIO traffic.

---
 rtl/tlp_pkg.sv | 69 ++++++
 rtl/tlp_completer_regfile.sv | 35 +++
 rtl/tlp_completer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/tlp_pkg.sv
// Shared TLP field encodings, header layouts and helpers for the single-DW completer.
package tlp_pkg;

   // {Fmt, Type} pairs as they appear in DW0[31:24]
   localparam logic [7:0] MRD32 = 8'h00;
   localparam logic [7:0] MRD64 = 8'h20;
   localparam logic [7:0] MWR32 = 8'h40;
   localparam logic [7:0] MWR64 = 8'h60;
   localparam logic [7:0] CPL   = 8'h0A;
   localparam logic [7:0] CPLD  = 8'h4A;

   localparam logic [2:0] CPL_SC = 3'b000;
   localparam logic [2:0] CPL_UR = 3'b001;

   typedef struct packed {
      logic [2:0]  fmt;
      logic [4:0]  tlp_type;
      logic [13:0] attrs;
      logic [9:0]  length;
   } req_dw0_t;

   typedef struct packed {
      logic [15:0] req_id;
      logic [7:0]  tag;
      logic [3:0]  last_be;
      logic [3:0]  first_be;
   } req_dw1_t;

   typedef struct packed {
      logic [15:0] completer_id;
      logic [2:0]  status;
      logic        bcm;
      logic [11:0] byte_count;
   } cpl_dw1_t;

   typedef struct packed {
      logic [15:0] requester_id;
      logic [7:0]  tag;
      logic        rsvd;
      logic [6:0]  lower_addr;
   } cpl_dw2_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RESP  = 2'd1,
      DRAIN = 2'd2
   } fsm_state_t;

   function automatic logic [1:0] lowest_be_idx(input logic [3:0] be);
      logic [1:0] idx;
      idx = 2'd0;
      if (be[0])      idx = 2'd0;
      else if (be[1]) idx = 2'd1;
      else if (be[2]) idx = 2'd2;
      else if (be[3]) idx = 2'd3;
      return idx;
   endfunction

   function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/tlp_completer_regfile.sv
// NUM_REGS x 32 register file: byte-enabled write port and registered read port.
module tlp_completer_regfile #(
   parameter int NUM_REGS = 16,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [3:0]       wr_be,
   input  logic [31:0]      wr_data,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [31:0]      rd_data
);
   import tlp_pkg::*;

   logic [31:0] regs [NUM_REGS];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         rd_data <= '0;
      end else begin
         if (wr_en) regs[wr_idx] <= merge_be(regs[wr_idx], wr_data, wr_be);
         // A read landing on the edge that retires a write returns the merged word,
         // so a read following a write back-to-back sees the write.
         if (rd_en) begin
            if (wr_en && (wr_idx == rd_idx)) rd_data <= merge_be(regs[wr_idx], wr_data, wr_be);
            else                             rd_data <= regs[rd_idx];
         end
      end
   end

endmodule

// File: rtl/tlp_completer.sv
// Single-DW MMIO completer: decodes memory TLPs on rx, answers reads with CplD, others with UR.
// Optional error counter output err_count enabled by defining TLP_COMPLETER_ERR_CNT_EN.
module tlp_completer #(
   parameter int          NUM_REGS     = 16,
   parameter logic [15:0] COMPLETER_ID = 16'h0100
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [255:0] tlp_rx_st_data,
   input  logic [2:0]   tlp_rx_st_empty,
   input  logic         tlp_rx_st_startofpacket,
   input  logic         tlp_rx_st_endofpacket,
   input  logic         tlp_rx_st_valid,
   output logic         tlp_rx_st_ready,
   output logic [255:0] tlp_tx_st_data,
   output logic [2:0]   tlp_tx_st_empty,
   output logic         tlp_tx_st_startofpacket,
   output logic         tlp_tx_st_endofpacket,
   output logic         tlp_tx_st_valid,
   input  logic         tlp_tx_st_ready
`ifdef TLP_COMPLETER_ERR_CNT_EN
   ,output logic [15:0] err_count
`endif
);
   import tlp_pkg::*;

   localparam int IDX_W = $clog2(NUM_REGS);

   // Streams: a beat moves on an edge where valid && ready; tx holds every field
   // stable while valid && !ready, and rx_ready is a registered function of state.
   fsm_state_t state;
   req_dw0_t   dw0;
   req_dw1_t   dw1;
   logic [31:0] rx_addr, rx_wdata, rd_data;
   logic [95:0] tx_hdr;
   logic        tx_is_cpld, drain_after;
   logic        wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic        is_4dw, is_mem, is_mrd1, is_mwr1, rx_fire, sop_fire, rd_en;
   cpl_dw1_t    cpl_dw1;
   cpl_dw2_t    cpl_dw2;

   assign dw0      = tlp_rx_st_data[31:0];
   assign dw1      = tlp_rx_st_data[63:32];
   assign is_4dw   = dw0.fmt[0];
   assign rx_addr  = is_4dw ? tlp_rx_st_data[127:96]  : tlp_rx_st_data[95:64];
   assign rx_wdata = is_4dw ? tlp_rx_st_data[159:128] : tlp_rx_st_data[127:96];
   assign is_mem   = (dw0.tlp_type == 5'b00000);
   assign is_mrd1  = is_mem && (dw0.fmt[2:1] == 2'b00) && (dw0.length == 10'd1);
   assign is_mwr1  = is_mem && (dw0.fmt[2:1] == 2'b01) && (dw0.length == 10'd1)
                     && tlp_rx_st_endofpacket;
   assign rx_fire  = tlp_rx_st_valid && tlp_rx_st_ready;
   assign sop_fire = rx_fire && tlp_rx_st_startofpacket && (state == IDLE);
   assign rd_en    = sop_fire && is_mrd1;

   always_comb begin
      cpl_dw1              = '0;
      cpl_dw1.completer_id = COMPLETER_ID;
      cpl_dw1.status       = is_mrd1 ? CPL_SC : CPL_UR;
      cpl_dw1.bcm          = 1'b0;
      cpl_dw1.byte_count   = 12'd4;
      cpl_dw2              = '0;
      cpl_dw2.requester_id = dw1.req_id;
      cpl_dw2.tag          = dw1.tag;
      // UR completions report lower address 0; only a real read reflects the address
      if (is_mrd1)
         cpl_dw2.lower_addr = (dw1.first_be == 4'd0) ? {rx_addr[6:2], 2'b00}
                                                     : {rx_addr[6:2], lowest_be_idx(dw1.first_be)};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state                   <= IDLE;
         tlp_rx_st_ready         <= 1'b0;
         tlp_tx_st_valid         <= 1'b0;
         tlp_tx_st_startofpacket <= 1'b0;
         tlp_tx_st_endofpacket   <= 1'b0;
         tlp_tx_st_empty         <= 3'd0;
         tx_hdr                  <= '0;
         tx_is_cpld              <= 1'b0;
         drain_after             <= 1'b0;
         wr_en                   <= 1'b0;
         wr_idx                  <= '0;
         wr_be                   <= 4'd0;
         wr_data                 <= '0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE: begin
               tlp_rx_st_ready <= 1'b1;
               if (sop_fire) begin
                  if (is_mwr1) begin
                     wr_en   <= 1'b1;
                     wr_idx  <= rx_addr[IDX_W+1:2];
                     wr_be   <= dw1.first_be;
                     wr_data <= rx_wdata;
                  end else if (!dw0.fmt[1]) begin
                     state                   <= RESP;
                     tlp_rx_st_ready         <= 1'b0;
                     tlp_tx_st_valid         <= 1'b1;
                     tlp_tx_st_startofpacket <= 1'b1;
                     tlp_tx_st_endofpacket   <= 1'b1;
                     tlp_tx_st_empty         <= is_mrd1 ? 3'd4 : 3'd5;
                     tx_hdr      <= {cpl_dw2, cpl_dw1,
                                     is_mrd1 ? {CPLD, 14'd0, 10'd1} : {CPL, 14'd0, 10'd0}};
                     tx_is_cpld  <= is_mrd1;
                     drain_after <= !tlp_rx_st_endofpacket;
                  end else if (!tlp_rx_st_endofpacket) begin
                     state <= DRAIN;
                  end
               end
            end
            RESP: begin
               if (tlp_tx_st_ready) begin
                  state                   <= drain_after ? DRAIN : IDLE;
                  tlp_rx_st_ready         <= 1'b1;
                  tlp_tx_st_valid         <= 1'b0;
                  tlp_tx_st_startofpacket <= 1'b0;
                  tlp_tx_st_endofpacket   <= 1'b0;
                  tlp_tx_st_empty         <= 3'd0;
                  tx_hdr                  <= '0;
                  tx_is_cpld              <= 1'b0;
                  drain_after             <= 1'b0;
               end
            end
            DRAIN: begin
               tlp_rx_st_ready <= 1'b1;
               if (rx_fire && tlp_rx_st_endofpacket) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read data lives in the regfile's output register and is held until the next read.
   assign tlp_tx_st_data = {128'd0, tx_is_cpld ? rd_data : 32'd0, tx_hdr};

   tlp_completer_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_be   (wr_be),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_idx  (rx_addr[IDX_W+1:2]),
      .rd_data (rd_data)
   );

`ifdef TLP_COMPLETER_ERR_CNT_EN
   // Every accepted header that is neither a clean 1DW write nor a 1DW read is an error.
   logic err_inc;
   assign err_inc = sop_fire && !is_mwr1 && !is_mrd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                            err_count <= 16'd0;
      else if (err_inc && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
   end
`endif

   logic unused_bits;
   assign unused_bits = ^{tlp_rx_st_data[255:160], tlp_rx_st_empty, dw0.attrs, dw1.last_be,
                          rx_addr[31:7], rx_addr[1:0]};

endmodule
